// File: rtl/pueo_threshold_loader.sv
// rtl/pueo_threshold_loader.sv - threshold memory that shifts NBEAMS entries into the beam cascade, then commits them
// Optional host readback port (rd_addr_i/rd_dat_o) is built only when THRESH_READBACK_EN is defined.
module pueo_threshold_loader #(
    parameter int NBEAMS     = 48,
    parameter int WR_SPACING = 1,
    localparam int AW        = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [35:0]   host_dat_i,
    input  logic          host_wr_i,
    output logic          host_err_o,
    input  logic          start_i,
    input  logic [1:0]    upd_mask_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [35:0]   thresh_o,
    output logic [1:0]    thresh_wr_o,
    output logic [1:0]    thresh_update_o
`ifdef THRESH_READBACK_EN
    ,
    input  logic [AW-1:0] rd_addr_i,
    output logic [35:0]   rd_dat_o
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WRITE  = 3'd2,
        GAP    = 3'd3,
        UPDATE = 3'd4,
        DONE   = 3'd5
    } stateType;

    localparam logic [AW:0]   BEAMS_W   = (AW + 1)'(NBEAMS);
    localparam logic [AW-1:0] LAST_BEAM = AW'(NBEAMS - 1);
    localparam logic [3:0]    GAP_LAST  = (WR_SPACING > 1) ? 4'(WR_SPACING - 2) : 4'd0;
    localparam bit            HAS_GAP   = (WR_SPACING > 1);

    stateType      state;
    stateType      nextState;

    logic [35:0]   threshMem [NBEAMS];
    logic [35:0]   fetchData;
    logic [35:0]   lastThresh;
    logic [AW-1:0] beamCnt;
    logic [AW-1:0] rdIdx;
    logic [3:0]    gapCnt;
    logic [1:0]    updMask;
    logic          finalWr;
    logic          startOk;
    logic          hostInRange;
    logic          hostWrOk;
    logic          hostWrBad;

    assign startOk     = (state == IDLE) && start_i;
    assign hostInRange = ({1'b0, host_addr_i} < BEAMS_W);
    assign hostWrOk    = host_wr_i && !busy_o && hostInRange;
    assign hostWrBad   = host_wr_i && (busy_o || !hostInRange);

    // Back-to-back writes need the next entry prefetched while the current one is on the bus.
    always_comb begin
        rdIdx = beamCnt;
        if (state == WRITE && beamCnt != '0) begin
            rdIdx = beamCnt - 1'b1;
        end
    end

    // Memory has no reset so an aborted load leaves the programmed thresholds intact.
    always_ff @(posedge clk_i) begin
        if (hostWrOk) begin
            threshMem[host_addr_i] <= host_dat_i;
        end
        fetchData <= threshMem[rdIdx];
    end

`ifdef THRESH_READBACK_EN
    always_ff @(posedge clk_i) begin
        rd_dat_o <= threshMem[rd_addr_i];
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:   if (start_i) nextState = FETCH;
            FETCH:  nextState = WRITE;
            WRITE: begin
                if (HAS_GAP) begin
                    nextState = GAP;
                end else if (beamCnt == '0) begin
                    nextState = UPDATE;
                end else begin
                    nextState = WRITE;
                end
            end
            GAP:    if (gapCnt == GAP_LAST) nextState = finalWr ? UPDATE : WRITE;
            UPDATE: nextState = DONE;
            DONE:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // finalWr separates the gap after the last write from the gaps between writes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beamCnt    <= '0;
            gapCnt     <= '0;
            updMask    <= '0;
            finalWr    <= 1'b0;
            lastThresh <= '0;
            host_err_o <= 1'b0;
        end else begin
            if (startOk) begin
                beamCnt <= LAST_BEAM;
                updMask <= upd_mask_i;
                finalWr <= 1'b0;
            end
            if (state == WRITE) begin
                lastThresh <= fetchData;
                gapCnt     <= '0;
                if (beamCnt != '0) begin
                    beamCnt <= beamCnt - 1'b1;
                end else begin
                    finalWr <= 1'b1;
                end
            end
            if (state == GAP) begin
                gapCnt <= gapCnt + 1'b1;
            end
            if (startOk) begin
                host_err_o <= 1'b0;
            end
            if (hostWrBad) begin
                host_err_o <= 1'b1;
            end
        end
    end

    always_comb begin
        busy_o          = (state != IDLE);
        done_o          = (state == DONE);
        thresh_wr_o     = (state == WRITE) ? 2'b11 : 2'b00;
        thresh_update_o = (state == UPDATE) ? updMask : 2'b00;
        thresh_o        = (state == WRITE) ? fetchData : lastThresh;
    end

endmodule
